puc_update_unit: RTL and testbench
==================================

# puc_update_unit

Training and checking stage for the uncache-attribute predictor. It records each instruction-fetch request together with its predicted uncache bit in a small in-order queue. When the real attribute returns from address translation, it compares the two. It drives the predictor's 7-bit write bus (`{we, waddr[4:0], wdata}`) and raises a one-cycle refetch request on mismatch. It sits between the fetch stage, which holds the predictor, and the translation/AXI request logic, which returns the real attribute.

## Interface
Parameters:
- `DEPTH`, 4: outstanding fetch requests tracked; power of two, 2..8.
- `IDX_LSB`, 12: low bit of the PC slice used as predictor index; index is `pc[IDX_LSB+4:IDX_LSB]`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-high (asserted when 1).
- `req_valid_i`  in  1  fetch request issued this cycle.
- `req_ready_o`  out  1  queue can accept a request.
- `req_pc_i`  in  32  fetch PC.
- `req_uncache_pred_i`  in  1  predicted uncache bit used for this request.
- `rsp_valid_i`  in  1  real attribute for the oldest outstanding request.
- `rsp_uncache_i`  in  1  real uncache bit.
- `flush_i`  in  1  pipeline redirect; all outstanding requests become wrong-path.
- `wbus_o`  out  `PucWbusWidth` (7)  `{we, waddr, wdata}` to the predictor.
- `mispred_o`  out  1  one-cycle refetch request.
- `mispred_pc_o`  out  32  PC to refetch; valid while `mispred_o`=1.
- `count_o`  out  $clog2(DEPTH)+1  live queue occupancy.

## Operation
- FIFO entry: `{pc[31:0], pred}`.
  - A push occurs when `req_valid_i & req_ready_o`.
  - A pop occurs when `rsp_valid_i` in RUN with the queue non-empty.
- FSM states: RUN, DRAIN.
- RUN:
  - `req_ready_o = (count < DEPTH)`; it does not depend on a same-cycle pop.
  - Pop with `pred != rsp_uncache_i`:
    - register `wbus_o = {1, head.pc idx, rsp_uncache_i}`;
    - register `mispred_o`=1 and `mispred_pc_o` = head.pc;
    - set `discard` = count − 1, plus 1 if a push is accepted the same cycle;
    - clear the FIFO pointers;
    - go to DRAIN if `discard` ≠ 0, else stay in RUN.
  - Pop with a match: `wbus_o.we`=0, because the prediction is already correct and no write is needed.
  - `rsp_valid_i` with an empty queue is a protocol violation. It is ignored with no state change.
- `flush_i` in RUN:
  - set `discard` = count − (pop this cycle) + (push this cycle);
  - clear the FIFO;
  - suppress `mispred_o` for that cycle;
  - still issue the `wbus_o` update if the popped entry mismatched, because the real attribute is authoritative;
  - go to DRAIN if `discard` ≠ 0.
- DRAIN:
  - `req_ready_o`=0.
  - Each `rsp_valid_i` decrements `discard` with no comparison and no write.
  - When `discard` goes 1 → 0, return to RUN on the next cycle.
  - `flush_i` is ignored, because everything is already being discarded.
- `count_o` reports FIFO occupancy, not `discard`.

## Timing
- Reset values: FIFO empty, `count_o`=0, state RUN, `discard`=0, `wbus_o`=7'b0, `mispred_o`=0, `mispred_pc_o`=0, `req_ready_o`=1.
- `wbus_o` and `mispred_o` are registered. They appear 1 cycle after the `rsp_valid_i` cycle and stay high for exactly 1 cycle.
- The predictor bypasses same-cycle writes. A read of the same index in the cycle `wbus_o.we`=1 therefore already sees the new value.
- Simultaneous push and pop in RUN leaves `count` unchanged; full-with-pop still refuses the push.
- Pointers wrap modulo DEPTH; `count` uses the extra bit to distinguish full from empty.
- A reset asserted mid-DRAIN or with outputs high returns everything to reset values immediately (asynchronous).

## Structure
- Width macros (`PucAddrWidth`, `PucWbusWidth`) and the `RstEnable` level come from the shared width/define header; no new package is needed.
- One sub-module is natural: `puc_req_fifo`, a parameterised synchronous FIFO with push, pop, clear, count, head data.
- The FSM, discard counter and output registers stay in `puc_update_unit`.

## Test plan
- Push PC 0x1C000000 with pred=1, respond real=1 → `wbus_o.we`=0, `mispred_o`=0, `count_o` 1→0.
- Push PC 0x1C003000 with pred=1, respond real=0 → next cycle `wbus_o`={1,5'd3,0}, `mispred_o`=1, `mispred_pc_o`=0x1C003000.
- Push 4 (DEPTH), mismatch on the first response → `req_ready_o`=0 for exactly 3 further responses, then RUN with `count_o`=0.
- Fill to 4 entries → `req_ready_o`=0. Then pop and push in the same cycle → the push is refused and `count_o`=3.
- 2 outstanding, `flush_i` coincident with a mismatching response → `wbus_o.we`=1, `mispred_o`=0, 1 response discarded.
- Assert reset while in DRAIN → all outputs return to reset values and `req_ready_o`=1 after release.

Source files
------------

// File: rtl/puc_update_unit_pkg.sv
// Shared widths, reset level and FSM encodings for the uncache-attribute predictor update stage.
package puc_update_unit_pkg;

  localparam int unsigned PucAddrWidth = 32;
  localparam int unsigned PucWbusWidth = 7;
  localparam logic        RstEnable    = 1'b1;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

endpackage

// File: rtl/puc_update_unit_if.sv
// Fetch-request / translation-response / predictor-write bundle of puc_update_unit.
interface puc_update_unit_if #(
  parameter int unsigned DEPTH = 4
);
  import puc_update_unit_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [PucAddrWidth-1:0] req_pc_i;
  logic                    req_uncache_pred_i;
  logic                    rsp_valid_i;
  logic                    rsp_uncache_i;
  logic                    flush_i;
  logic [PucWbusWidth-1:0] wbus_o;
  logic                    mispred_o;
  logic [PucAddrWidth-1:0] mispred_pc_o;
  logic [CW-1:0]           count_o;

  modport master (
    output req_valid_i, req_pc_i, req_uncache_pred_i, rsp_valid_i, rsp_uncache_i, flush_i,
    input  req_ready_o, wbus_o, mispred_o, mispred_pc_o, count_o
  );

  modport slave (
    input  req_valid_i, req_pc_i, req_uncache_pred_i, rsp_valid_i, rsp_uncache_i, flush_i,
    output req_ready_o, wbus_o, mispred_o, mispred_pc_o, count_o
  );

endinterface

// File: rtl/puc_req_fifo.sv
// In-order queue of outstanding fetch requests; DEPTH must be a power of two.
module puc_req_fifo
  import puc_update_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;

  // Pointers wrap naturally at DEPTH; count carries the extra bit for full vs empty.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n == RstEnable) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/puc_update_unit.sv
// Compares predicted vs. translated uncache attribute per fetch, trains the predictor
// and requests a refetch on mismatch; wrong-path responses are drained afterwards.
module puc_update_unit
  import puc_update_unit_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned IDX_LSB = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  puc_update_unit_if.slave   bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [0:0]              state_q, state_d;
  logic [CW-1:0]           discard_q, discard_d;
  logic [PucWbusWidth-1:0] wbus_q, wbus_d;
  logic                    mispred_q, mispred_d;
  logic [PucAddrWidth-1:0] mispred_pc_q, mispred_pc_d;

  logic [CW-1:0]           count;
  logic [PucAddrWidth:0]   head;
  logic [PucAddrWidth-1:0] head_pc;
  logic                    head_pred;
  logic                    run, ready, push, pop, mism, clear;

  puc_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PucAddrWidth + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push & ~clear),
    .pop_i   (pop & ~clear),
    .clear_i (clear),
    .wdata_i ({bus.req_pc_i, bus.req_uncache_pred_i}),
    .rdata_o (head),
    .count_o (count)
  );

  assign head_pc   = head[PucAddrWidth:1];
  assign head_pred = head[0];

  always_comb begin
    run   = (state_q == ST_RUN);
    ready = run && (count < CW'(DEPTH));
    push  = bus.req_valid_i & ready;
    pop   = run & bus.rsp_valid_i & (count != '0);
    mism  = pop & (head_pred != bus.rsp_uncache_i);
  end

  // A push accepted in the same cycle as a clear is already in flight, so it is counted as discard.
  always_comb begin
    state_d      = state_q;
    discard_d    = discard_q;
    clear        = 1'b0;
    wbus_d       = '0;
    mispred_d    = 1'b0;
    mispred_pc_d = mispred_pc_q;
    if (run) begin
      if (mism) wbus_d = {1'b1, head_pc[IDX_LSB+4:IDX_LSB], bus.rsp_uncache_i};
      if (bus.flush_i) begin
        clear     = 1'b1;
        discard_d = count - CW'(pop) + CW'(push);
      end else if (mism) begin
        clear        = 1'b1;
        mispred_d    = 1'b1;
        mispred_pc_d = head_pc;
        discard_d    = count - CW'(1) + CW'(push);
      end
      if (clear && (discard_d != '0)) state_d = ST_DRAIN;
    end else if (bus.rsp_valid_i) begin
      discard_d = discard_q - CW'(1);
      if (discard_q == CW'(1)) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n == RstEnable) begin
      state_q      <= ST_RUN;
      discard_q    <= '0;
      wbus_q       <= '0;
      mispred_q    <= 1'b0;
      mispred_pc_q <= '0;
    end else begin
      state_q      <= state_d;
      discard_q    <= discard_d;
      wbus_q       <= wbus_d;
      mispred_q    <= mispred_d;
      mispred_pc_q <= mispred_pc_d;
    end
  end

  assign bus.req_ready_o  = ready;
  assign bus.wbus_o       = wbus_q;
  assign bus.mispred_o    = mispred_q;
  assign bus.mispred_pc_o = mispred_pc_q;
  assign bus.count_o      = count;

endmodule

// File: tb/tb_puc_update_unit.sv
// Directed self-checking bench for puc_update_unit with hand-computed expectations.
module tb_puc_update_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  puc_update_unit_if #(.DEPTH(4)) bus ();

  puc_update_unit #(
    .DEPTH   (4),
    .IDX_LSB (12)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic pred);
    bus.req_valid_i        = 1'b1;
    bus.req_pc_i           = pc;
    bus.req_uncache_pred_i = pred;
    step();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic rsp(input logic real_uc, input logic flush);
    bus.rsp_valid_i   = 1'b1;
    bus.rsp_uncache_i = real_uc;
    bus.flush_i       = flush;
    step();
    bus.rsp_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
  endtask

  initial begin
    bus.req_valid_i        = 1'b0;
    bus.req_pc_i           = '0;
    bus.req_uncache_pred_i = 1'b0;
    bus.rsp_valid_i        = 1'b0;
    bus.rsp_uncache_i      = 1'b0;
    bus.flush_i            = 1'b0;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #20 rst_n = 1'b0;
    #1;

    chk("rst_count",   32'(bus.count_o), 0);
    chk("rst_ready",   32'(bus.req_ready_o), 1);
    chk("rst_wbus",    32'(bus.wbus_o), 0);
    chk("rst_mispred", 32'(bus.mispred_o), 0);
    chk("rst_mpc",     bus.mispred_pc_o, 0);

    // Response with empty queue is ignored
    rsp(1'b1, 1'b0);
    chk("empty_rsp_wbus",  32'(bus.wbus_o), 0);
    chk("empty_rsp_count", 32'(bus.count_o), 0);
    chk("empty_rsp_ready", 32'(bus.req_ready_o), 1);

    // Matching prediction
    push(32'h1C00_0000, 1'b1);
    chk("match_count1", 32'(bus.count_o), 1);
    rsp(1'b1, 1'b0);
    chk("match_wbus",    32'(bus.wbus_o), 0);
    chk("match_mispred", 32'(bus.mispred_o), 0);
    chk("match_count0",  32'(bus.count_o), 0);

    // Single mismatch, nothing else outstanding
    push(32'h1C00_3000, 1'b1);
    rsp(1'b0, 1'b0);
    chk("mm_wbus",    32'(bus.wbus_o), 32'h46);
    chk("mm_mispred", 32'(bus.mispred_o), 1);
    chk("mm_pc",      bus.mispred_pc_o, 32'h1C00_3000);
    chk("mm_ready",   32'(bus.req_ready_o), 1);
    step();
    chk("mm_wbus_1cyc",    32'(bus.wbus_o), 0);
    chk("mm_mispred_1cyc", 32'(bus.mispred_o), 0);

    // Four outstanding, first mismatches: three responses drained
    push(32'h1C00_1000, 1'b0);
    push(32'h1C00_2000, 1'b0);
    push(32'h1C00_4000, 1'b0);
    push(32'h1C00_5000, 1'b0);
    chk("full_count", 32'(bus.count_o), 4);
    chk("full_ready", 32'(bus.req_ready_o), 0);
    rsp(1'b1, 1'b0);
    chk("dr_wbus",    32'(bus.wbus_o), 32'h43);
    chk("dr_mispred", 32'(bus.mispred_o), 1);
    chk("dr_pc",      bus.mispred_pc_o, 32'h1C00_1000);
    chk("dr_count",   32'(bus.count_o), 0);
    chk("dr_ready0",  32'(bus.req_ready_o), 0);
    bus.req_valid_i = 1'b1;
    bus.req_pc_i    = 32'h1C00_9000;
    rsp(1'b1, 1'b1);
    bus.req_valid_i = 1'b0;
    chk("dr1_ready",   32'(bus.req_ready_o), 0);
    chk("dr1_count",   32'(bus.count_o), 0);
    chk("dr1_wbus",    32'(bus.wbus_o), 0);
    chk("dr1_mispred", 32'(bus.mispred_o), 0);
    rsp(1'b0, 1'b0);
    chk("dr2_ready", 32'(bus.req_ready_o), 0);
    rsp(1'b0, 1'b0);
    chk("dr3_ready", 32'(bus.req_ready_o), 1);
    chk("dr3_count", 32'(bus.count_o), 0);

    // Full queue: pop and push in the same cycle refuses the push
    for (int i = 0; i < 4; i++) push(32'h1C01_0000 + 32'(i << 12), 1'b0);
    chk("fill_ready", 32'(bus.req_ready_o), 0);
    bus.req_valid_i = 1'b1;
    bus.req_pc_i    = 32'h1C0F_0000;
    rsp(1'b0, 1'b0);
    bus.req_valid_i = 1'b0;
    chk("fullpp_count", 32'(bus.count_o), 3);
    chk("fullpp_wbus",  32'(bus.wbus_o), 0);
    chk("fullpp_ready", 32'(bus.req_ready_o), 1);
    for (int i = 0; i < 3; i++) rsp(1'b0, 1'b0);
    chk("fullpp_empty", 32'(bus.count_o), 0);

    // Flush coincident with a mismatching response, two outstanding
    push(32'h1C00_7000, 1'b0);
    push(32'h1C00_8000, 1'b0);
    chk("fl_count2", 32'(bus.count_o), 2);
    rsp(1'b1, 1'b1);
    chk("fl_wbus",    32'(bus.wbus_o), 32'h4F);
    chk("fl_mispred", 32'(bus.mispred_o), 0);
    chk("fl_count",   32'(bus.count_o), 0);
    chk("fl_ready0",  32'(bus.req_ready_o), 0);
    rsp(1'b0, 1'b0);
    chk("fl_ready1",  32'(bus.req_ready_o), 1);
    chk("fl_wbus_dr", 32'(bus.wbus_o), 0);

    // Asynchronous reset while draining with outputs high
    push(32'h1C00_A000, 1'b0);
    push(32'h1C00_B000, 1'b0);
    push(32'h1C00_C000, 1'b0);
    rsp(1'b1, 1'b0);
    chk("pre_rst_mispred", 32'(bus.mispred_o), 1);
    chk("pre_rst_ready",   32'(bus.req_ready_o), 0);
    #2 rst_n = 1'b1;
    #1;
    chk("arst_wbus",    32'(bus.wbus_o), 0);
    chk("arst_mispred", 32'(bus.mispred_o), 0);
    chk("arst_mpc",     bus.mispred_pc_o, 0);
    chk("arst_count",   32'(bus.count_o), 0);
    step();
    rst_n = 1'b0;
    step();
    chk("post_rst_ready", 32'(bus.req_ready_o), 1);
    chk("post_rst_count", 32'(bus.count_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
